vec_chunk_fifo: RTL
===================

VEC_CHUNK_FIFO -- requirements
Module: vec_chunk_fifo

Interface
REQ-001 SHALL have parameter WorkingRegs, default 4: number of signed 8-bit lanes per chunk.
REQ-002 SHALL have parameter InVecLength, default 16: elements per vector, a multiple of WorkingRegs; ChunksPerVec = InVecLength/WorkingRegs.
REQ-003 SHALL have parameter Depth, default 8: chunk capacity, a power of two, at least ChunksPerVec.
REQ-004 SHALL have port clk_in, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst_in, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port wr_en_in, input, 1: push strobe, driven by the upstream stage's req_chunk_out.
REQ-007 SHALL have port wr_data_in, input, signed [WorkingRegs-1:0][7:0]: chunk to push.
REQ-008 SHALL have port rd_req_in, input, 1: pop strobe, driven by the downstream stage's req_chunk_in.
REQ-009 SHALL have port rd_data_out, output, signed [WorkingRegs-1:0][7:0]: head chunk (first-word fall-through).
REQ-010 SHALL have port data_ready_out, output, 1: at least one complete vector is buffered; drives downstream in_data_ready.
REQ-011 SHALL have port empty_out, output, 1: zero chunks stored.
REQ-012 SHALL have port full_out, output, 1: Depth chunks stored.
REQ-013 SHALL have port count_out, output, $clog2(Depth)+1: chunks stored.
REQ-014 SHALL have port overflow_out, output, 1: sticky dropped-write flag.
REQ-015 SHALL have port underflow_out, output, 1: sticky empty-read flag.

Function
REQ-016 SHALL store chunks in a Depth-entry array with write and read pointers of $clog2(Depth) bits that wrap from Depth-1 to 0.
REQ-017 SHALL accept a push at a posedge when wr_en_in=1 and (not full or rd_req_in=1); data is written at the write pointer, and the pointer advances.
REQ-018 SHALL present rd_data_out combinationally from the entry at the read pointer, so data is valid in the same cycle rd_req_in is asserted, with zero-cycle read latency.
REQ-019 SHALL perform a pop at a posedge when rd_req_in=1 and not empty; the read pointer advances.
REQ-020 SHALL drive rd_data_out to all zeros while empty.
REQ-021 SHALL, on simultaneous push and pop while full, perform both and leave count unchanged.
REQ-022 SHALL, on simultaneous push and pop while empty, perform only the push (no bypass) and set underflow_out.
REQ-023 SHALL, on a push while full without a pop, discard the data, leave pointers unchanged and set overflow_out.
REQ-024 SHALL, on a pop while empty, leave pointers unchanged and set underflow_out.
REQ-025 SHALL hold overflow_out and underflow_out set until reset.
REQ-026 SHALL keep a write-chunk index (0..ChunksPerVec-1) that advances per accepted push and wraps, and a read-chunk index that advances per performed pop and wraps.
REQ-027 SHALL keep a vector counter: +1 when an accepted push wraps the write-chunk index, -1 when a pop wraps the read-chunk index, unchanged when both occur in the same cycle.
REQ-028 SHALL assert data_ready_out, registered, exactly when the vector counter is nonzero.
REQ-029 SHALL update count_out, empty_out and full_out as registered values consistent with the pointers after each edge.

Reset
REQ-030 SHALL, while rst_in=0 at a posedge, zero both pointers, both chunk indices, the vector counter, count_out, overflow_out and underflow_out; set empty_out=1, full_out=0 and data_ready_out=0; and ignore wr_en_in and rd_req_in.
REQ-031 SHALL, on reset asserted mid-vector, discard all buffered chunks with no partial vector surviving; array contents need not be cleared.

Verification (WorkingRegs=4, InVecLength=16, Depth=8)
REQ-032 SHALL test: push chunks C0..C3 on 4 consecutive cycles -> data_ready_out=0 after 3 pushes and 1 the cycle after the 4th push; count_out=4.
REQ-033 SHALL test: then pop 4 cycles -> rd_data_out=C0,C1,C2,C3 in order on the pop cycles; data_ready_out=0 and empty_out=1 after the 4th pop.
REQ-034 SHALL test: push 8 chunks, then a 9th with no pop -> full_out=1, overflow_out=1, count_out=8; popping returns chunks 1..8 with the 9th absent.
REQ-035 SHALL test: at full, push plus pop together for 4 cycles -> count_out stays 8, pointers wrap, and data order is preserved.
REQ-036 SHALL test: on empty, rd_req_in=1 with wr_en_in=1 -> underflow_out=1, count_out=1, and rd_data_out equals the pushed chunk the next cycle.
REQ-037 SHALL test: push 6 chunks, assert rst_in=0 for 1 cycle -> count_out=0, empty_out=1, data_ready_out=0, flags cleared; then 4 pushes -> data_ready_out=1.

Source files
------------

// File: rtl/vec_chunk_fifo.sv
// Chunk FIFO between vector stages: first-word fall-through read, sticky error flags,
// and a whole-vector counter that tells the downstream stage a complete vector is buffered.
module vec_chunk_fifo #(
    parameter int WorkingRegs = 4,
    parameter int InVecLength = 16,
    parameter int Depth       = 8
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               wr_en_in,
    input  logic signed [WorkingRegs-1:0][7:0] wr_data_in,
    input  logic                               rd_req_in,
    output logic signed [WorkingRegs-1:0][7:0] rd_data_out,
    output logic                               data_ready_out,
    output logic                               empty_out,
    output logic                               full_out,
    output logic [$clog2(Depth):0]             count_out,
    output logic                               overflow_out,
    output logic                               underflow_out
);
    localparam int ChunksPerVec = InVecLength / WorkingRegs;
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth) + 1;
    localparam int IW = (ChunksPerVec > 1) ? $clog2(ChunksPerVec) : 1;

    logic signed [WorkingRegs-1:0][7:0] mem [Depth];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [CW-1:0] vec_cnt;

    logic          push, pop, wr_wrap, rd_wrap;
    logic [CW-1:0] count_nxt, vec_nxt;
    logic [IW-1:0] wr_idx_nxt, rd_idx_nxt;

    // A full FIFO still accepts a push when a pop frees the slot in the same edge.
    always_comb begin
        push       = wr_en_in && (!full_out || rd_req_in);
        pop        = rd_req_in && !empty_out;
        wr_wrap    = push && (wr_idx == IW'(ChunksPerVec - 1));
        rd_wrap    = pop && (rd_idx == IW'(ChunksPerVec - 1));
        wr_idx_nxt = wr_idx;
        rd_idx_nxt = rd_idx;
        if (push) wr_idx_nxt = wr_wrap ? '0 : wr_idx + 1'b1;
        if (pop)  rd_idx_nxt = rd_wrap ? '0 : rd_idx + 1'b1;
        count_nxt  = count_out + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        vec_nxt    = vec_cnt;
        if (wr_wrap && !rd_wrap)      vec_nxt = vec_cnt + 1'b1;
        else if (!wr_wrap && rd_wrap) vec_nxt = vec_cnt - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && push) mem[wr_ptr] <= wr_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            vec_cnt        <= '0;
            count_out      <= '0;
            empty_out      <= 1'b1;
            full_out       <= 1'b0;
            data_ready_out <= 1'b0;
            overflow_out   <= 1'b0;
            underflow_out  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            wr_idx         <= wr_idx_nxt;
            rd_idx         <= rd_idx_nxt;
            vec_cnt        <= vec_nxt;
            count_out      <= count_nxt;
            empty_out      <= (count_nxt == '0);
            full_out       <= (count_nxt == CW'(Depth));
            data_ready_out <= (vec_nxt != '0);
            if (wr_en_in && full_out && !rd_req_in) overflow_out <= 1'b1;
            if (rd_req_in && empty_out)             underflow_out <= 1'b1;
        end
    end

    assign rd_data_out = empty_out ? '0 : mem[rd_ptr];
endmodule
